data_sram_bridge: RTL and testbench

DATA_SRAM_BRIDGE -- requirements
Module: data_sram_bridge

---
 rtl/data_sram_bridge.sv | 129 ++++++++++++
 tb/tb_data_sram_bridge.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_sram_bridge.sv
// Bridges the pipeline's single-cycle data SRAM port onto a request/ack bus.
// It stalls the pipeline until the bus access completes.
// Optional macro DATA_SRAM_TIMEOUT_EN adds an 8-bit wait timeout and a sticky mem_err flag.
module data_sram_bridge (
    input  logic        clk,
    input  logic        rst,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_wen,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    output logic        stallreq,
    output logic        mem_req,
    output logic        mem_wr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        mem_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_reg;
    logic [31:2] addr_reg;
    logic [3:0]  wen_reg;
    logic [31:0] wdata_reg;
    logic [31:0] rdata_reg;
    logic        mem_req_reg;
    logic [3:0]  mem_be_reg;

    logic        wr_next;
    logic [3:0]  be_next;

    // Reads fetch the whole word; writes pass the lane enables through.
    assign wr_next = |data_sram_wen;
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_be
            assign be_next[gi] = data_sram_wen[gi] | ~wr_next;
        end
    endgenerate

`ifdef DATA_SRAM_TIMEOUT_EN
    logic [7:0] wait_cnt_reg;
    logic       err_reg;
    assign mem_err = err_reg;
`else
    assign mem_err = 1'b0;
`endif

    // Bus outputs come straight from registers latched at REQ entry, so they
    // cannot move while the slave is still working on the access.
    assign mem_req         = mem_req_reg;
    assign mem_wr          = |wen_reg;
    assign mem_be          = mem_be_reg;
    assign mem_addr        = {addr_reg, 2'b00};
    assign mem_wdata       = wdata_reg;
    assign data_sram_rdata = rdata_reg;

    // The stall must rise in the same cycle the request appears.
    assign stallreq = ~rst & ((state_reg == IDLE && data_sram_en) || state_reg == REQ);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            addr_reg     <= '0;
            wen_reg      <= '0;
            wdata_reg    <= '0;
            rdata_reg    <= '0;
            mem_req_reg  <= 1'b0;
            mem_be_reg   <= '0;
`ifdef DATA_SRAM_TIMEOUT_EN
            wait_cnt_reg <= '0;
            err_reg      <= 1'b0;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    if (data_sram_en) begin
                        addr_reg     <= data_sram_addr[31:2];
                        wen_reg      <= data_sram_wen;
                        wdata_reg    <= data_sram_wdata;
                        mem_be_reg   <= be_next;
                        mem_req_reg  <= 1'b1;
                        state_reg    <= REQ;
`ifdef DATA_SRAM_TIMEOUT_EN
                        wait_cnt_reg <= '0;
`endif
                    end
                end
                REQ: begin
                    if (mem_ack) begin
                        if (wen_reg == 4'b0000) begin
                            rdata_reg <= mem_rdata;
                        end
                        mem_req_reg <= 1'b0;
                        state_reg   <= DONE;
                    end
`ifdef DATA_SRAM_TIMEOUT_EN
                    else if (wait_cnt_reg == 8'hFF) begin
                        // Give up: poison load data and flag the error until reset.
                        if (wen_reg == 4'b0000) begin
                            rdata_reg <= 32'hDEAD_BEEF;
                        end
                        err_reg     <= 1'b1;
                        mem_req_reg <= 1'b0;
                        state_reg   <= DONE;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + 8'd1;
                    end
`endif
                end
                DONE: begin
                    // The pipeline still shows the old request here; drop it.
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_sram_bridge.sv
// Directed bench for data_sram_bridge: table of bus transactions plus hand-written
// reset, stray-ack and timeout sequences.
module tb_data_sram_bridge;

    logic        clk;
    logic        rst;
    logic        data_sram_en;
    logic [3:0]  data_sram_wen;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic [31:0] data_sram_rdata;
    logic        stallreq;
    logic        mem_req;
    logic        mem_wr;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        mem_err;

    data_sram_bridge dut (
        .clk             (clk),
        .rst             (rst),
        .data_sram_en    (data_sram_en),
        .data_sram_wen   (data_sram_wen),
        .data_sram_addr  (data_sram_addr),
        .data_sram_wdata (data_sram_wdata),
        .data_sram_rdata (data_sram_rdata),
        .stallreq        (stallreq),
        .mem_req         (mem_req),
        .mem_wr          (mem_wr),
        .mem_be          (mem_be),
        .mem_addr        (mem_addr),
        .mem_wdata       (mem_wdata),
        .mem_ack         (mem_ack),
        .mem_rdata       (mem_rdata),
        .mem_err         (mem_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          delay;
        logic [31:0] rdata_in;
        logic [31:0] exp_addr;
        logic [3:0]  exp_be;
        logic        exp_wr;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t        vecs [7];
    int          n_checks;
    int          n_fail;
    logic [31:0] last_rdata;
    int          bus_starts;
    logic        prev_req;

    // Counts distinct bus transactions (rising edges of mem_req).
    always @(negedge clk) begin
        if (mem_req && !prev_req) bus_starts++;
        prev_req = mem_req;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Entered and left at 1 time unit after a rising edge with the DUT in IDLE.
    task automatic run_txn(input int idx, input vec_t v);
        data_sram_en    = 1'b1;
        data_sram_wen   = v.wen;
        data_sram_addr  = v.addr;
        data_sram_wdata = v.wdata;
        mem_ack         = 1'b0;
        @(negedge clk);
        chk("c0_stallreq", {31'd0, stallreq}, 32'd1);
        chk("c0_mem_req", {31'd0, mem_req}, 32'd0);
        chk("c0_rdata_hold", data_sram_rdata, last_rdata);
        @(posedge clk); #1;
        for (int k = 0; k <= v.delay; k++) begin
            if (k == v.delay) begin
                mem_ack   = 1'b1;
                mem_rdata = v.rdata_in;
            end
            @(negedge clk);
            chk("req_mem_req", {31'd0, mem_req}, 32'd1);
            chk("req_stallreq", {31'd0, stallreq}, 32'd1);
            chk("req_mem_addr", mem_addr, v.exp_addr);
            chk("req_mem_be", {28'd0, mem_be}, {28'd0, v.exp_be});
            chk("req_mem_wr", {31'd0, mem_wr}, {31'd0, v.exp_wr});
            chk("req_mem_wdata", mem_wdata, v.wdata);
            @(posedge clk); #1;
            mem_ack   = 1'b0;
            mem_rdata = 32'h0BAD_0BAD;
        end
        // DONE: pipeline still presents the request, and a stray ack arrives.
        mem_ack   = 1'b1;
        mem_rdata = 32'hBAD0_BAD0;
        @(negedge clk);
        chk("done_stallreq", {31'd0, stallreq}, 32'd0);
        chk("done_mem_req", {31'd0, mem_req}, 32'd0);
        chk("done_rdata", data_sram_rdata, v.exp_rdata);
        @(posedge clk); #1;
        mem_ack      = 1'b0;
        data_sram_en = 1'b0;
        last_rdata   = v.exp_rdata;
        $display("txn %0d wen=%b addr=%h delay=%0d rdata=%h", idx, v.wen, v.addr, v.delay, data_sram_rdata);
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        bus_starts = 0;
        prev_req   = 1'b0;
        last_rdata = 32'h0;

        vecs[0] = '{4'b0000, 32'h0000_1006, 32'h0, 0, 32'h1234_5678, 32'h0000_1004, 4'hF, 1'b0, 32'h1234_5678};
        vecs[1] = '{4'b0100, 32'h0000_2002, 32'h00AB_0000, 3, 32'h0, 32'h0000_2000, 4'b0100, 1'b1, 32'h1234_5678};
        vecs[2] = '{4'b0000, 32'h0000_3FFF, 32'h0, 1, 32'hA5A5_5A5A, 32'h0000_3FFC, 4'hF, 1'b0, 32'hA5A5_5A5A};
        vecs[3] = '{4'b1111, 32'hFFFF_FFFC, 32'hCAFE_F00D, 0, 32'h0, 32'hFFFF_FFFC, 4'hF, 1'b1, 32'hA5A5_5A5A};
        vecs[4] = '{4'b0011, 32'h0000_0010, 32'h0000_BEEF, 2, 32'h0, 32'h0000_0010, 4'b0011, 1'b1, 32'hA5A5_5A5A};
        vecs[5] = '{4'b0000, 32'h8000_0001, 32'h0, 2, 32'h0000_0000, 32'h8000_0000, 4'hF, 1'b0, 32'h0000_0000};
        vecs[6] = '{4'b0000, 32'h0000_0004, 32'h0, 0, 32'hFFFF_FFFF, 32'h0000_0004, 4'hF, 1'b0, 32'hFFFF_FFFF};

        // Reset state, with a request pending to show stallreq is masked.
        rst             = 1'b1;
        data_sram_en    = 1'b1;
        data_sram_wen   = 4'b1111;
        data_sram_addr  = 32'h1234_5678;
        data_sram_wdata = 32'hFFFF_FFFF;
        mem_ack         = 1'b0;
        mem_rdata       = 32'h0;
        #12;
        chk("rst_stallreq", {31'd0, stallreq}, 32'd0);
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
        chk("rst_mem_be", {28'd0, mem_be}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_rdata", data_sram_rdata, 32'd0);
        chk("rst_mem_err", {31'd0, mem_err}, 32'd0);
        @(posedge clk); #1;
        rst          = 1'b0;
        data_sram_en = 1'b0;
        $display("reset checked");

        // Stray ack while idle must be ignored.
        mem_ack   = 1'b1;
        mem_rdata = 32'h55AA_55AA;
        @(negedge clk);
        chk("idle_ack_stallreq", {31'd0, stallreq}, 32'd0);
        chk("idle_ack_mem_req", {31'd0, mem_req}, 32'd0);
        @(posedge clk); #1;
        mem_ack = 1'b0;
        @(negedge clk);
        chk("idle_ack_rdata", data_sram_rdata, 32'd0);
        chk("idle_ack_stay_idle", {31'd0, mem_req}, 32'd0);
        @(posedge clk); #1;
        $display("stray ack in IDLE checked");

        // Back-to-back transactions from the table.
        bus_starts = 0;
        for (int i = 0; i < 7; i++) begin
            run_txn(i, vecs[i]);
        end
        @(negedge clk);
        chk("bus_txn_count", bus_starts, 32'd7);
        @(posedge clk); #1;

        // Reset in the second REQ cycle abandons the access.
        data_sram_en   = 1'b1;
        data_sram_wen  = 4'b0000;
        data_sram_addr = 32'h0000_0040;
        @(posedge clk); #1;
        data_sram_en = 1'b0;
        @(posedge clk); #1;
        #2 rst = 1'b1;
        #1;
        chk("midrst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("midrst_stallreq", {31'd0, stallreq}, 32'd0);
        chk("midrst_mem_addr", mem_addr, 32'd0);
        chk("midrst_rdata", data_sram_rdata, 32'd0);
        @(posedge clk); #1;
        rst       = 1'b0;
        mem_ack   = 1'b1;
        mem_rdata = 32'h7777_7777;
        @(negedge clk);
        chk("late_ack_mem_req", {31'd0, mem_req}, 32'd0);
        chk("late_ack_stallreq", {31'd0, stallreq}, 32'd0);
        @(posedge clk); #1;
        mem_ack = 1'b0;
        @(negedge clk);
        chk("late_ack_rdata", data_sram_rdata, 32'd0);
        chk("late_ack_idle", {31'd0, mem_req}, 32'd0);
        @(posedge clk); #1;
        last_rdata = 32'h0;
        $display("reset mid-access checked");

`ifdef DATA_SRAM_TIMEOUT_EN
        begin
            int  n_stall;
            bit  dropped;
            n_stall = 0;
            dropped = 1'b0;
            data_sram_en   = 1'b1;
            data_sram_wen  = 4'b0000;
            data_sram_addr = 32'h0000_0100;
            @(posedge clk); #1;
            data_sram_en = 1'b0;
            for (int i = 0; i < 400 && !dropped; i++) begin
                @(negedge clk);
                if (stallreq) n_stall++;
                else dropped = 1'b1;
            end
            chk("to_dropped", {31'd0, dropped}, 32'd1);
            chk("to_window", {31'd0, (n_stall >= 255 && n_stall <= 256)}, 32'd1);
            chk("to_rdata", data_sram_rdata, 32'hDEAD_BEEF);
            chk("to_mem_err", {31'd0, mem_err}, 32'd1);
            chk("to_mem_req", {31'd0, mem_req}, 32'd0);
            @(posedge clk); #1;
            $display("timeout after %0d REQ cycles", n_stall);
            last_rdata = 32'hDEAD_BEEF;
            run_txn(7, vecs[0]);
            @(negedge clk);
            chk("to_err_sticky", {31'd0, mem_err}, 32'd1);
            @(posedge clk); #1;
            rst = 1'b1;
            #2;
            chk("to_err_clear", {31'd0, mem_err}, 32'd0);
            @(posedge clk); #1;
            rst = 1'b0;
        end
`else
        begin
            bit dropped;
            dropped = 1'b0;
            data_sram_en   = 1'b1;
            data_sram_wen  = 4'b0000;
            data_sram_addr = 32'h0000_0100;
            @(posedge clk); #1;
            data_sram_en = 1'b0;
            for (int i = 0; i < 1000; i++) begin
                @(negedge clk);
                if (!stallreq || !mem_req) dropped = 1'b1;
            end
            chk("hang_stall_held", {31'd0, dropped}, 32'd0);
            chk("hang_mem_err", {31'd0, mem_err}, 32'd0);
            chk("hang_rdata", data_sram_rdata, 32'd0);
            $display("no-timeout wait held 1000 cycles");
            @(posedge clk); #1;
            rst = 1'b1;
            #2;
            chk("hang_rst_stall", {31'd0, stallreq}, 32'd0);
            @(posedge clk); #1;
            rst = 1'b0;
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
